// File: rtl/maxpool2d_relu.sv
// POOLxPOOL max pooling (stride POOL) with optional ReLU. Reads a CHW feature map
// from a 1-cycle-latency BRAM and writes the pooled CHW map to an output BRAM.
// All outputs are registered, so they trail the FSM state by one cycle. Each
// window costs POOL^2+2 cycles.
module maxpool2d_relu #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned IMG_SIZE   = 28,
    parameter int unsigned POOL       = 2,
    parameter int unsigned RELU_EN    = 1,
    localparam int unsigned OS     = IMG_SIZE / POOL,
    localparam int unsigned IN_N   = CHANNELS * IMG_SIZE * IMG_SIZE,
    localparam int unsigned OUT_N  = CHANNELS * OS * OS,
    localparam int unsigned IN_AW  = (IN_N > 1) ? $clog2(IN_N) : 1,
    localparam int unsigned OUT_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [IN_AW-1:0]             in_addr,
    output logic                         in_en,
    input  logic signed [DATA_WIDTH-1:0] in_q,
    output logic [OUT_AW-1:0]            out_addr,
    output logic                         out_en,
    output logic                         out_we,
    output logic signed [DATA_WIDTH-1:0] out_d,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SW = (OS > 1) ? $clog2(OS) : 1;
    localparam int unsigned KW = (POOL > 1) ? $clog2(POOL) : 1;

    typedef enum logic [2:0] {StIdle, StRead, StLast, StWrite, StDone} state_e;

    state_e state_q;

    logic [CW-1:0] ch_q;
    logic [SW-1:0] pr_q, pc_q;
    logic [KW-1:0] kr_q, kc_q;

    logic signed [DATA_WIDTH-1:0] max_q;

    // Read pipeline tracking: iss_first_q marks the read being issued as the
    // window's first; rd_valid_q/rd_first_q mark the sample now on in_q.
    logic iss_first_q;
    logic rd_valid_q;
    logic rd_first_q;

    logic                         kc_last, kr_last, pc_last, pr_last, ch_last, win_last;
    logic [IN_AW-1:0]             rd_addr;
    logic [OUT_AW-1:0]            wr_addr;
    logic signed [DATA_WIDTH-1:0] cand;
    logic signed [DATA_WIDTH-1:0] pooled;

    // Counter wrap flags, BRAM addresses and the running max including the sample on in_q.
    always_comb begin
        kc_last  = (kc_q == KW'(POOL - 1));
        kr_last  = (kr_q == KW'(POOL - 1));
        pc_last  = (pc_q == SW'(OS - 1));
        pr_last  = (pr_q == SW'(OS - 1));
        ch_last  = (ch_q == CW'(CHANNELS - 1));
        win_last = ch_last && pr_last && pc_last;

        rd_addr = IN_AW'(((32'(ch_q) * IMG_SIZE + 32'(pr_q) * POOL + 32'(kr_q)) * IMG_SIZE)
                         + 32'(pc_q) * POOL + 32'(kc_q));
        wr_addr = OUT_AW'((32'(ch_q) * OS + 32'(pr_q)) * OS + 32'(pc_q));

        // First sample of a window loads directly; later ones take the signed max.
        cand   = (rd_first_q || (in_q > max_q)) ? in_q : max_q;
        pooled = ((RELU_EN != 0) && cand[DATA_WIDTH-1]) ? '0 : cand;
    end

    // Control FSM with window counters, max register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            pr_q        <= '0;
            pc_q        <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            max_q       <= '0;
            iss_first_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_first_q  <= 1'b0;
            in_addr     <= '0;
            in_en       <= 1'b0;
            out_addr    <= '0;
            out_en      <= 1'b0;
            out_we      <= 1'b0;
            out_d       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            in_en       <= 1'b0;
            iss_first_q <= 1'b0;
            out_en      <= 1'b0;
            out_we      <= 1'b0;
            done        <= 1'b0;
            rd_valid_q  <= in_en;
            rd_first_q  <= iss_first_q;
            if (rd_valid_q) begin
                max_q <= cand;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRead;
                        ch_q    <= '0;
                        pr_q    <= '0;
                        pc_q    <= '0;
                        kr_q    <= '0;
                        kc_q    <= '0;
                    end
                end
                StRead: begin
                    busy        <= 1'b1;
                    in_en       <= 1'b1;
                    in_addr     <= rd_addr;
                    iss_first_q <= (kr_q == '0) && (kc_q == '0);
                    if (kc_last) begin
                        kc_q <= '0;
                        if (kr_last) begin
                            kr_q    <= '0;
                            state_q <= StLast;
                        end else begin
                            kr_q <= kr_q + 1'b1;
                        end
                    end else begin
                        kc_q <= kc_q + 1'b1;
                    end
                end
                StLast: begin
                    state_q <= StWrite;
                end
                StWrite: begin
                    out_en   <= 1'b1;
                    out_we   <= 1'b1;
                    out_addr <= wr_addr;
                    out_d    <= pooled;
                    if (win_last) begin
                        ch_q    <= '0;
                        pr_q    <= '0;
                        pc_q    <= '0;
                        state_q <= StDone;
                    end else begin
                        state_q <= StRead;
                        if (pc_last) begin
                            pc_q <= '0;
                            if (pr_last) begin
                                pr_q <= '0;
                                ch_q <= ch_q + 1'b1;
                            end else begin
                                pr_q <= pr_q + 1'b1;
                            end
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2d_relu.sv
// Bench for maxpool2d_relu: two instances (RELU_EN=0 and 1) read the same 2x4x4
// input map. Expected writes are queued per run; a negedge monitor pops and checks.
module tb_maxpool2d_relu;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic clk;
    logic reset;
    logic start;

    logic signed [15:0] mem [0:31];

    logic [4:0]         in_addr0, in_addr1;
    logic               in_en0, in_en1;
    logic signed [15:0] rq0, rq1;
    logic [2:0]         out_addr0, out_addr1;
    logic               out_en0, out_en1, out_we0, out_we1;
    logic signed [15:0] out_d0, out_d1;
    logic               busy0, busy1, done0, done1;

    int   checks;
    int   failures;
    exp_t expq [2][$];
    logic [7:0] hit [2];
    int   wr_cnt [2];
    int   done_cnt [2];

    int exp_base [2][8] = '{'{6, 8, 14, 16, -1, -3, -9, -11},
                            '{6, 8, 14, 16, 0, 0, 0, 0}};
    int exp_ext  [2][8] = '{'{-32768, 32767, 9, -7, -1, -3, -9, -11},
                            '{0, 32767, 9, 0, 0, 0, 0, 0}};

    maxpool2d_relu #(
        .DATA_WIDTH(16), .CHANNELS(2), .IMG_SIZE(4), .POOL(2), .RELU_EN(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr0), .in_en(in_en0), .in_q(rq0),
        .out_addr(out_addr0), .out_en(out_en0), .out_we(out_we0), .out_d(out_d0),
        .busy(busy0), .done(done0)
    );

    maxpool2d_relu #(
        .DATA_WIDTH(16), .CHANNELS(2), .IMG_SIZE(4), .POOL(2), .RELU_EN(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr1), .in_en(in_en1), .in_q(rq1),
        .out_addr(out_addr1), .out_en(out_en1), .out_we(out_we1), .out_d(out_d1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input BRAM models, 1-cycle read latency.
    always @(posedge clk) begin
        if (in_en0) rq0 <= mem[in_addr0];
        if (in_en1) rq1 <= mem[in_addr1];
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic mon(input int id, input logic en, input logic we, input logic [2:0] a,
                       input logic signed [15:0] d, input logic dn);
        exp_t e;
        if (en || we) begin
            chk($sformatf("dut%0d en_we_pair", id), int'({en, we}), 3);
        end
        if (we) begin
            if (expq[id].size() == 0) begin
                chk($sformatf("dut%0d unexpected_write addr", id), int'(a), -1);
            end else begin
                e = expq[id].pop_front();
                chk($sformatf("dut%0d write_addr", id), int'(a), e.addr);
                chk($sformatf("dut%0d write_data@%0d", id, e.addr), int'(d), e.data);
            end
            if (hit[id][a]) chk($sformatf("dut%0d duplicate_write", id), int'(a), -1);
            hit[id][a] = 1'b1;
            wr_cnt[id]++;
        end
        if (dn) done_cnt[id]++;
    endtask

    // Scoreboard monitor: compare every presented write against the queue head.
    always @(negedge clk) begin
        mon(0, out_en0, out_we0, out_addr0, out_d0, done0);
        mon(1, out_en1, out_we1, out_addr1, out_d1, done1);
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " dut0 in_en"}, int'(in_en0), 0);
        chk({tag, " dut0 in_addr"}, int'(in_addr0), 0);
        chk({tag, " dut0 out_en"}, int'(out_en0), 0);
        chk({tag, " dut0 out_we"}, int'(out_we0), 0);
        chk({tag, " dut0 out_addr"}, int'(out_addr0), 0);
        chk({tag, " dut0 out_d"}, int'(out_d0), 0);
        chk({tag, " dut0 busy"}, int'(busy0), 0);
        chk({tag, " dut0 done"}, int'(done0), 0);
        chk({tag, " dut1 in_en/out_we/busy/done"},
            int'({in_en1, out_en1, out_we1, busy1, done1}), 0);
        chk({tag, " dut1 out_d"}, int'(out_d1), 0);
    endtask

    task automatic load_base();
        for (int i = 0; i < 16; i++) begin
            mem[i]      = 16'(i + 1);
            mem[16 + i] = 16'(-(i + 1));
        end
    endtask

    task automatic load_ext();
        int e [16] = '{-32768, -32768, 32767, -32768, -32768, -32768, 0, -1,
                       5, 5, -7, -7, 5, 9, -7, -7};
        for (int i = 0; i < 16; i++) mem[i] = 16'(e[i]);
    endtask

    // One run: queue expectations, pulse start, track latency/busy, optional
    // extra start pulse or mid-run reset abort at a given cycle after accept.
    task automatic do_run(input string tag, input int mode, input int extra_at,
                          input int abort_at);
        int lat;
        int busy_bad;
        exp_t e;
        for (int id = 0; id < 2; id++) begin
            expq[id].delete();
            hit[id]      = 8'h00;
            wr_cnt[id]   = 0;
            done_cnt[id] = 0;
            for (int i = 0; i < 8; i++) begin
                e.addr = i;
                e.data = (mode == 1) ? exp_ext[id][i] : exp_base[id][i];
                expq[id].push_back(e);
            end
        end
        lat      = -1;
        busy_bad = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);  // accept edge
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == extra_at);
            if (cyc == abort_at) begin
                reset = 1'b0;
                #1;
                chk_idle_outputs({tag, " abort"});
                repeat (5) @(posedge clk);
                #1;
                chk({tag, " writes_before_abort"}, wr_cnt[0], 2);
                chk({tag, " no_done_after_abort"}, done_cnt[0] + done_cnt[1], 0);
                chk({tag, " idle_after_abort"}, int'({busy0, busy1, out_we0, out_we1}), 0);
                expq[0].delete();
                expq[1].delete();
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (done0) begin
                lat = cyc;
                break;
            end
            if (!busy0 || !busy1) busy_bad++;
        end
        start = 1'b0;
        chk({tag, " latency"}, lat, 49);
        chk({tag, " dut1 done_with_dut0"}, int'(done1), 1);
        chk({tag, " busy_gaps"}, busy_bad, 0);
        chk({tag, " busy_low_at_done"}, int'({busy0, busy1}), 0);
        @(posedge clk);
        #1;
        chk({tag, " done_single_cycle"}, int'({done0, done1}), 0);
        chk({tag, " done_pulses"}, done_cnt[0] * 10 + done_cnt[1], 11);
        chk({tag, " dut0 writes"}, wr_cnt[0], 8);
        chk({tag, " dut1 writes"}, wr_cnt[1], 8);
        chk({tag, " dut0 addr_cover"}, int'(hit[0]), 255);
        chk({tag, " dut1 addr_cover"}, int'(hit[1]), 255);
        chk({tag, " pending_expected"}, expq[0].size() + expq[1].size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        load_base();
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        do_run("base", 0, 0, 0);
        do_run("start_while_busy", 0, 7, 0);
        load_ext();
        do_run("extremes", 1, 0, 0);
        load_base();
        do_run("abort", 0, 0, 14);
        do_run("after_abort", 0, 0, 0);
        do_run("back_to_back", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
